marlann_qpi_responder: RTL
==========================

// Module: marlann_qpi_responder
// PURPOSE
// - Accelerator-side QPI (4-bit SPI) responder answering the ctrlsoc ml_* initiator (ml_clk/ml_csb/ml_io0..3).
// - Oversamples the QPI pins in the accelerator clock domain and decodes command bytes.
// - Converts write bursts into a byte stream for the core and read bursts into QPI output nibbles.
// - Reports sticky error flags in a status byte.
// PARAMETERS
// - DUMMY_NIBBLES  2  SCK rising edges between command byte and first read nibble (cmds 0x03/0x05)
// PORTS
// - clk         in   1  accelerator clock; QPI SCK must be <= clk/4
// - reset       in   1  asynchronous, active-high reset
// - qpi_clk     in   1  SCK from initiator, idle low, mode 0
// - qpi_csb     in   1  chip select, active low
// - qpi_di      in   4  io3..io0 input
// - qpi_do      out  4  io3..io0 output value
// - qpi_oe      out  1  output enable for all four io pins
// - wr_valid    out  1  received write byte valid, single-cycle pulse
// - wr_data     out  8  received write byte
// - wr_ready    in   1  core can accept a byte
// - rd_valid    in   1  core has a read byte available
// - rd_data     in   8  read byte from core
// - rd_ready    out  1  single-cycle pulse: rd_data consumed
// - core_busy   in   1  reported in status bit 7
// - core_err    in   1  reported in status bit 6
// BEHAVIOUR
// - Reset: qpi_do=0, qpi_oe=0, wr_valid=0, wr_data=0, rd_ready=0, state=IDLE, ovf=udf=0.
// - qpi_clk, qpi_csb, qpi_di pass through 2-flop synchronizers; edges detected on synchronized SCK.
// - Nibbles sampled on detected SCK rise, MSB nibble first; output nibble updated on detected SCK fall.
// - States: IDLE -> CMD (csb falls) -> WRITE | DUMMY -> READ | STATUS | IGNORE; any state -> IDLE on synchronized csb high.
// - CMD: 2 nibbles form the command. 0x02 -> WRITE; 0x03 -> DUMMY then READ; 0x05 -> DUMMY then STATUS; others -> IGNORE (qpi_oe stays 0).
// - WRITE: each completed byte: if wr_ready then wr_valid=1 for exactly one cycle, the cycle after the completing edge; else byte dropped, ovf<=1.
// - DUMMY: counts DUMMY_NIBBLES rising edges; qpi_oe asserted on the last dummy fall edge.
// - READ: at each byte boundary, one cycle before the high nibble drives: if rd_valid, latch rd_data, pulse rd_ready; else send 0x00, udf<=1.
// - STATUS: byte {core_busy, core_err, 4'b0, ovf, udf}, repeated while csb low. ovf/udf cleared when csb rises after >=1 full status byte sent.
// - csb rise mid-byte: partial byte discarded; no wr_valid or rd_ready for it; qpi_oe=0 next cycle.
// - Event priority: a flag set and the status clear in the same cycle -> set wins.
// - Reset mid-transfer: immediate IDLE, outputs to reset values. A transfer resumes only after csb high then low again.
// - qpi_oe is never 1 in IDLE, CMD, WRITE or IGNORE.
// CONFIGURATION
// - MARLANN_QPI_CMDCNT_EN defined: 16-bit wrapping counter of accepted commands (0x02/0x03/0x05/0x06).
//   - Cmd 0x06 -> DUMMY then sends count high byte, then low byte, repeating.
//   - Count 0xFFFF wraps to 0x0000; reset clears it.
// - Undefined: no counter; 0x06 -> IGNORE.
// TESTING
// - Cmd 0x02 + bytes A5,3C, wr_ready=1 -> two wr_valid pulses, wr_data A5 then 3C; qpi_oe never 1.
// - Cmd 0x02 + byte 11 with wr_ready=0, then cmd 0x05 -> status byte 0x02. Next 0x05 -> 0x00.
// - Cmd 0x03, rd_data 0x7E valid, 2 dummy -> nibbles 7,E on qpi_do; one rd_ready pulse. rd_valid=0 next -> 0x00 sent, udf=1.
// - csb rise after 1 nibble of a write byte -> no wr_valid; next cmd 0x05 decodes correctly; qpi_oe=0 in IDLE.
// - Reset asserted in READ mid-byte -> qpi_oe=0 and state IDLE immediately; next cmd 0x05 -> 0x00.
// - With MARLANN_QPI_CMDCNT_EN: 3 commands then 0x06 -> count bytes 0x00,0x04; without it, qpi_oe stays 0.

Source files
------------

// File: rtl/marlann_qpi_responder.sv
// Accelerator-side QPI responder: oversamples ml_* pins, decodes commands, bridges bursts to the core.
// Optional MARLANN_QPI_CMDCNT_EN adds a 16-bit accepted-command counter readable with cmd 0x06.
`timescale 1ns/1ps

module marlann_qpi_responder #(
  parameter int DUMMY_NIBBLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       qpi_clk,
  input  logic       qpi_csb,
  input  logic [3:0] qpi_di,
  output logic [3:0] qpi_do,
  output logic       qpi_oe,
  output logic       wr_valid,
  output logic [7:0] wr_data,
  input  logic       wr_ready,
  input  logic       rd_valid,
  input  logic [7:0] rd_data,
  output logic       rd_ready,
  input  logic       core_busy,
  input  logic       core_err
);

  // state    | meaning
  // S_IDLE   | csb high or waiting for a fresh csb fall after reset
  // S_CMD    | shifting in the two command nibbles
  // S_WRITE  | receiving bytes for the core
  // S_DUMMY  | counting dummy SCK rises before a read-type response
  // S_READ   | streaming core bytes out
  // S_STATUS | streaming the status byte out
  // S_IGNORE | unknown command, bus stays released
  // S_COUNT  | streaming the command counter (optional build only)
  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_WRITE, S_DUMMY, S_READ, S_STATUS, S_IGNORE, S_COUNT
  } state_t;

  localparam logic [7:0] DUMMY_LD = 8'(DUMMY_NIBBLES);

  state_t     state, state_nx, dummy_tgt;
  logic [1:0] sck_s, csb_s;
  logic [3:0] di_s1, di_s2;
  logic       sck_d, fall_d;
  logic       sck, csb, rise, fall;
  logic       armed, nib, tx_lo, lo_on_bus;
  logic [3:0] rx_hi;
  logic [7:0] rx_byte, tx_buf, tx_byte, dcnt;
  logic       tx_state, byte_done, load;
  logic       ovf, udf, status_done;
  logic       ovf_set, udf_set, status_set, flag_clr;

`ifdef MARLANN_QPI_CMDCNT_EN
  logic [15:0] cmd_cnt;
  logic        cnt_sel;
`endif

  assign sck       = sck_s[1];
  assign csb       = csb_s[1];
  assign rise      = sck & ~sck_d;
  assign fall      = ~sck & sck_d;
  assign rx_byte   = {rx_hi, di_s2};
  assign byte_done = rise & nib;
  assign tx_state  = (state == S_READ) || (state == S_STATUS) || (state == S_COUNT);
  assign load      = fall & tx_state & ~tx_lo & ~csb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_s  <= 2'b00;
      sck_d  <= 1'b0;
      csb_s  <= 2'b11;
      di_s1  <= 4'h0;
      di_s2  <= 4'h0;
      fall_d <= 1'b0;
    end else begin
      sck_s  <= {sck_s[0], qpi_clk};
      sck_d  <= sck_s[1];
      csb_s  <= {csb_s[0], qpi_csb};
      di_s1  <= qpi_di;
      di_s2  <= di_s1;
      fall_d <= fall;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (armed && !csb) state_nx = S_CMD;
      S_CMD: begin
        if (byte_done) begin
          case (rx_byte)
            8'h02:   state_nx = S_WRITE;
            8'h03:   state_nx = S_DUMMY;
            8'h05:   state_nx = S_DUMMY;
`ifdef MARLANN_QPI_CMDCNT_EN
            8'h06:   state_nx = S_DUMMY;
`endif
            default: state_nx = S_IGNORE;
          endcase
        end
      end
      S_DUMMY: if (rise && dcnt == 8'd1) state_nx = dummy_tgt;
      default: ;
    endcase
    if (csb) state_nx = S_IDLE;
  end

  always_comb begin
    tx_byte = 8'h00;
    case (state)
      S_READ:   tx_byte = rd_valid ? rd_data : 8'h00;
      S_STATUS: tx_byte = {core_busy, core_err, 4'b0000, ovf, udf};
`ifdef MARLANN_QPI_CMDCNT_EN
      S_COUNT:  tx_byte = cnt_sel ? cmd_cnt[7:0] : cmd_cnt[15:8];
`endif
      default:  ;
    endcase
  end

  // The byte is fetched on the detected fall; its high nibble drives one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed     <= 1'b0;
      nib       <= 1'b0;
      rx_hi     <= 4'h0;
      tx_lo     <= 1'b0;
      lo_on_bus <= 1'b0;
      tx_buf    <= 8'h00;
      dcnt      <= 8'h00;
      dummy_tgt <= S_STATUS;
      qpi_do    <= 4'h0;
      qpi_oe    <= 1'b0;
      wr_valid  <= 1'b0;
      wr_data   <= 8'h00;
      rd_ready  <= 1'b0;
    end else begin
      wr_valid <= 1'b0;
      rd_ready <= 1'b0;
      if (csb) armed <= 1'b1;
      if (csb || state == S_IDLE) begin
        nib       <= 1'b0;
        tx_lo     <= 1'b0;
        lo_on_bus <= 1'b0;
        qpi_oe    <= 1'b0;
        qpi_do    <= 4'h0;
      end else begin
        if (rise && (state == S_CMD || state == S_WRITE)) begin
          nib   <= ~nib;
          rx_hi <= di_s2;
        end
        if (state == S_CMD && byte_done) begin
          dcnt      <= DUMMY_LD;
          dummy_tgt <= (rx_byte == 8'h03) ? S_READ :
                       (rx_byte == 8'h06) ? S_COUNT : S_STATUS;
        end
        if (state == S_DUMMY && rise) dcnt <= dcnt - 8'd1;
        if (state == S_WRITE && byte_done && wr_ready) begin
          wr_valid <= 1'b1;
          wr_data  <= rx_byte;
        end
        if (load) begin
          tx_buf <= tx_byte;
          if (state == S_READ && rd_valid) rd_ready <= 1'b1;
        end
        if (fall_d && tx_state) begin
          qpi_do    <= tx_lo ? tx_buf[3:0] : tx_buf[7:4];
          qpi_oe    <= 1'b1;
          tx_lo     <= ~tx_lo;
          lo_on_bus <= tx_lo;
        end
      end
    end
  end

  assign ovf_set    = (state == S_WRITE) && byte_done && !wr_ready && !csb;
  assign udf_set    = load && (state == S_READ) && !rd_valid;
  assign status_set = rise && (state == S_STATUS) && lo_on_bus && !csb;
  assign flag_clr   = csb && status_done;

  // Setting a flag outranks the clear that follows a completed status read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf         <= 1'b0;
      udf         <= 1'b0;
      status_done <= 1'b0;
    end else begin
      if (ovf_set)       ovf <= 1'b1;
      else if (flag_clr) ovf <= 1'b0;
      if (udf_set)       udf <= 1'b1;
      else if (flag_clr) udf <= 1'b0;
      if (flag_clr)        status_done <= 1'b0;
      else if (status_set) status_done <= 1'b1;
    end
  end

`ifdef MARLANN_QPI_CMDCNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_cnt <= 16'h0000;
      cnt_sel <= 1'b0;
    end else begin
      if (state == S_CMD && byte_done && !csb &&
          (rx_byte == 8'h02 || rx_byte == 8'h03 || rx_byte == 8'h05 || rx_byte == 8'h06))
        cmd_cnt <= cmd_cnt + 16'd1;
      if (csb || state == S_IDLE)            cnt_sel <= 1'b0;
      else if (load && state == S_COUNT)     cnt_sel <= ~cnt_sel;
    end
  end
`endif

endmodule
